// File: rtl/fetch_ctrl.sv
// Purpose : dual-issue fetch PC sequencer; walks the instruction ROM two
//           instructions (8 bytes) per cycle, honours stall and redirect.
// Latency : every output is registered; an input seen at a clock edge is
//           reflected on the outputs straight after that edge.
// Backpressure: stall=1 freezes pc and bundle_valid (the same pair is
//           re-fetched); a redirect overrides stall in that same cycle.
//
// Ports:
//   clk            sole clock, rising edge
//   reset          asynchronous, active-low
//   stall          downstream cannot take a new fetch pair this cycle
//   redirect_valid / redirect_pc   branch/exception redirect (bits [1:0] ignored)
//   pc             byte address of slot A (slot B is pc+4)
//   bundle_valid   fetch register holds a live instruction pair
//   flush          one-cycle pulse per accepted redirect
//   done           sequential fetch ran off the end of the ROM
//   state          FSM encoding: IDLE=0, RUN=1, STALL=2, DONE=3
//
// Build option: define FETCH_CTRL_PERF_EN to add the saturating 32-bit
// counters stall_cycles and redirect_cnt as extra outputs.
module fetch_ctrl #(
  parameter int          IROM_BYTES = 128,
  parameter logic [31:0] RESET_PC   = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic        bundle_valid,
  output logic        flush,
  output logic        done,
  output logic [1:0]  state
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] redirect_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] IROM_LIMIT = 32'(IROM_BYTES);
  localparam logic [31:0] PC_INIT    = RESET_PC & 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        bv_q, bv_d;
  logic        flush_q, flush_d;
  logic        done_q, done_d;
  logic        redir_take;
  logic [31:0] redir_target;

  // A pair at address a is fetchable when its second slot (a+4) is inside
  // the ROM. Arithmetic is plain 32-bit; addresses never approach wrap.
  function automatic logic in_range(input logic [31:0] a);
    return (a + 32'd4) < IROM_LIMIT;
  endfunction

  // Redirects are meaningless before the first fetch, so IDLE ignores them.
  assign redir_take   = redirect_valid && (state_q != S_IDLE);
  assign redir_target = redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bv_d    = bv_q;
    flush_d = 1'b0;

    if (redir_take) begin
      // Redirect beats stall; the stall takes effect from the next cycle.
      state_d = S_RUN;
      pc_d    = redir_target;
      bv_d    = 1'b0;
      flush_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_RUN;
          bv_d    = 1'b0;
        end
        S_RUN, S_STALL: begin
          if (stall) begin
            // Hold the pair; bundle_valid keeps whatever it already had.
            state_d = S_STALL;
          end else begin
            bv_d = in_range(pc_q);
            if (in_range(pc_q + 32'd8)) begin
              pc_d    = pc_q + 32'd8;
              state_d = S_RUN;
            end else begin
              // Next pair would fall off the ROM: park on the last pc.
              state_d = S_DONE;
            end
          end
        end
        default: begin
          bv_d = 1'b0;
        end
      endcase
    end

    // done tracks the state register exactly, so it can never coincide
    // with flush (a redirect always lands in RUN).
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= PC_INIT;
      bv_q    <= 1'b0;
      flush_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bv_q    <= bv_d;
      flush_q <= flush_d;
      done_q  <= done_d;
    end
  end

  assign pc           = pc_q;
  assign bundle_valid = bv_q;
  assign flush        = flush_q;
  assign done         = done_q;
  assign state        = state_q;

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] redirect_cnt_q;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= 32'd0;
      redirect_cnt_q <= 32'd0;
    end else begin
      if ((state_q == S_STALL) && (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (redir_take && (redirect_cnt_q != 32'hFFFF_FFFF)) begin
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign redirect_cnt = redirect_cnt_q;
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter IROM_BYTES, default 128, instruction ROM size in bytes; power of two, >= 16.
REQ-002 Parameter RESET_PC, default 32'd0, first fetch PC after reset; 4-byte aligned.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 stall  input  1  downstream (decode/rename) cannot accept a new fetch pair this cycle.
REQ-006 redirect_valid  input  1  branch/exception redirect request.
REQ-007 redirect_pc  input  32  redirect target byte address; bits [1:0] ignored, treated as 0.
REQ-008 pc  output  32  byte address of slot A driven to the fetch stage; slot B is pc+4.
REQ-009 bundle_valid  output  1  fetch register output (fd_reg) holds a live instruction pair; cycle-aligned with fd_reg.
REQ-010 flush  output  1  one-cycle pulse; downstream discards in-flight younger instructions.
REQ-011 done  output  1  sequential fetch has passed the end of the ROM.
REQ-012 state  output  2  current FSM state encoding (IDLE=0, RUN=1, STALL=2, DONE=3).

Function
REQ-013 FSM states SHALL be IDLE, RUN, STALL, DONE; pc, state, bundle_valid, flush, done SHALL all be registered.
REQ-014 IDLE: entered only from reset; leaves to RUN on the first clock after reset deasserts; pc holds RESET_PC; bundle_valid next = 0.
REQ-015 In-range test: a pair at pc is in range when pc+4 < IROM_BYTES (unsigned 32-bit; pc+4 and pc+8 computed at 32 bits, no wrap expected).
REQ-016 RUN, stall=0, redirect_valid=0: bundle_valid next = in-range(pc); if in-range(pc+8) then pc <= pc+8, else pc holds and state -> DONE.
REQ-017 RUN or STALL, stall=1, redirect_valid=0: pc holds, state -> STALL, bundle_valid holds its current value (fetch reloads the same pair).
REQ-018 STALL, stall=0, redirect_valid=0: behaves as RUN for that cycle (REQ-016), including PC advance.
REQ-019 Redirect has top priority in every state except IDLE: pc <= {redirect_pc[31:2],2'b00}; flush next = 1; bundle_valid next = 0; state -> RUN regardless of stall.
REQ-020 Redirect while stall=1: redirect wins; stall applies from the following cycle.
REQ-021 Redirect to an out-of-range target: state -> RUN for one cycle, then REQ-016 moves to DONE with bundle_valid = 0.
REQ-022 DONE: pc holds; bundle_valid next = 0; done = 1; exits only on redirect or reset.
REQ-023 flush SHALL be 1 for exactly one cycle per accepted redirect; back-to-back redirects give back-to-back flush pulses.
REQ-024 done SHALL equal (state == DONE) registered; done and flush never both 1.
REQ-025 Latency: a pc value presented in cycle N appears in fd_reg at the end of cycle N+1; bundle_valid asserts in the same cycle as fd_reg.

Reset
REQ-026 While reset = 0: pc = RESET_PC, state = IDLE, bundle_valid = 0, flush = 0, done = 0, all counters = 0, asynchronously.
REQ-027 Reset asserted mid-stall, mid-redirect or in DONE SHALL discard all pending state; no flush pulse is generated on release.
REQ-028 redirect_valid and stall are ignored in IDLE.

Configuration
REQ-029 Macro FETCH_CTRL_PERF_EN defined: outputs stall_cycles[31:0] (increments every cycle in STALL) and redirect_cnt[31:0] (increments per accepted redirect) are present, both saturate at 32'hFFFF_FFFF and reset to 0.
REQ-030 FETCH_CTRL_PERF_EN undefined: both ports and counters are absent; all other behaviour identical.

Verification
REQ-031 Reset release, no stall, IROM_BYTES=128: pc sequence 0,8,16,...,120; done = 1 after pc=120 is issued; bundle_valid high for exactly 16 cycles.
REQ-032 stall=1 for 3 cycles at pc=16: pc stays 16 for 3 cycles, bundle_valid stays 1, state = STALL; pc = 24 the cycle after stall drops.
REQ-033 redirect_valid=1, redirect_pc=32'h0000_0027 with stall=1 in RUN: pc = 32'h24 next cycle, flush = 1 for one cycle, bundle_valid = 0 that cycle.
REQ-034 In DONE, redirect to 32'h40: done drops, pc = 40, 48, ...; redirect to 32'h7C instead: one RUN cycle, then DONE, bundle_valid never 1.
REQ-035 reset pulsed low mid-stall at pc=56: outputs return to REQ-026 values immediately (before next clk edge); no flush on release.
REQ-036 With FETCH_CTRL_PERF_EN: 5 stall cycles + 2 redirects -> stall_cycles = 5, redirect_cnt = 2.
